// File: rtl/stack_ctrl.sv
// Stack sequencer: runs PUSH/POP/CALL/RET through the register-file ports
// and a ready-handshaked data memory. SP is register-file entry SP_IDX and
// the stack is full-descending.
module stack_ctrl #(
  parameter logic [3:0]  SP_IDX      = 4'd13,
  parameter logic [15:0] STACK_LIMIT = 16'hFF00,
  parameter logic [15:0] SP_EMPTY    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_reg,
  input  logic [15:0] cmd_data,
  output logic [3:0]  rf_ra,
  input  logic [15:0] rf_rd,
  output logic        rf_we,
  output logic [3:0]  rf_wa,
  output logic [15:0] rf_wd,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        done,
  output logic        err,
  output logic [15:0] pc_out,
  output logic        pc_valid
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_SP, S_RD_SRC, S_MEM_WR, S_MEM_RD, S_WB_REG, S_WB_SP, S_ERR
  } state_e;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00, OP_POP = 2'b01, OP_CALL = 2'b10, OP_RET = 2'b11
  } op_e;

  state_e      state, state_nx;
  op_e         op_q, op_nx;
  logic [3:0]  reg_q, reg_nx;
  logic [15:0] data_q, data_nx;
  logic [15:0] sp_q, sp_nx;
  logic [15:0] wdata_q, wdata_nx;
  logic [15:0] rdata_q, rdata_nx;
  logic [15:0] new_sp_q, new_sp_nx;
  logic        reject;

  logic        cmd_ready_nx, rf_we_nx, mem_we_nx, mem_re_nx;
  logic        done_nx, err_nx, pc_valid_nx;
  logic [3:0]  rf_ra_nx, rf_wa_nx;
  logic [15:0] rf_wd_nx, mem_addr_nx, mem_wdata_nx;

  // State and operand latches
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= OP_PUSH;
      reg_q    <= 4'd0;
      data_q   <= 16'd0;
      sp_q     <= 16'd0;
      wdata_q  <= 16'd0;
      rdata_q  <= 16'd0;
      new_sp_q <= 16'd0;
    end else begin
      state    <= state_nx;
      op_q     <= op_nx;
      reg_q    <= reg_nx;
      data_q   <= data_nx;
      sp_q     <= sp_nx;
      wdata_q  <= wdata_nx;
      rdata_q  <= rdata_nx;
      new_sp_q <= new_sp_nx;
    end
  end

  // Next-state, latch updates, and next-cycle output values decoded from them
  always_comb begin
    state_nx  = state;
    op_nx     = op_q;
    reg_nx    = reg_q;
    data_nx   = data_q;
    sp_nx     = sp_q;
    wdata_nx  = wdata_q;
    rdata_nx  = rdata_q;
    new_sp_nx = new_sp_q;
    reject    = 1'b0;

    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          op_nx    = op_e'(cmd_op);
          reg_nx   = cmd_reg;
          data_nx  = cmd_data;
          state_nx = S_RD_SP;
        end
      end
      S_RD_SP: begin
        sp_nx = rf_rd;
        case (op_q)
          OP_PUSH: reject = (rf_rd == STACK_LIMIT) || (reg_q > SP_IDX);
          OP_CALL: reject = (rf_rd == STACK_LIMIT);
          OP_POP:  reject = (rf_rd == SP_EMPTY) || (reg_q >= SP_IDX);
          default: reject = (rf_rd == SP_EMPTY);
        endcase
        if (reject) begin
          state_nx = S_ERR;
        end else begin
          case (op_q)
            OP_PUSH: state_nx = S_RD_SRC;
            OP_CALL: begin
              wdata_nx = data_q;
              state_nx = S_MEM_WR;
            end
            default: state_nx = S_MEM_RD;
          endcase
        end
      end
      S_RD_SRC: begin
        wdata_nx = rf_rd;
        state_nx = S_MEM_WR;
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          new_sp_nx = 16'(sp_q - 16'd1);
          state_nx  = S_WB_SP;
        end
      end
      S_MEM_RD: begin
        if (mem_ready) begin
          rdata_nx  = mem_rdata;
          new_sp_nx = 16'(sp_q + 16'd1);
          state_nx  = (op_q == OP_POP) ? S_WB_REG : S_WB_SP;
        end
      end
      S_WB_REG: state_nx = S_WB_SP;
      S_WB_SP:  state_nx = S_IDLE;
      S_ERR:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase

    cmd_ready_nx = (state_nx == S_IDLE);
    rf_ra_nx     = (state_nx == S_RD_SRC) ? reg_nx : SP_IDX;
    mem_we_nx    = (state_nx == S_MEM_WR);
    mem_re_nx    = (state_nx == S_MEM_RD);
    mem_addr_nx  = 16'd0;
    if (state_nx == S_MEM_WR) mem_addr_nx = 16'(sp_nx - 16'd1);
    if (state_nx == S_MEM_RD) mem_addr_nx = sp_nx;
    mem_wdata_nx = (state_nx == S_MEM_WR) ? wdata_nx : 16'd0;
    rf_we_nx     = (state_nx == S_WB_REG) || (state_nx == S_WB_SP);
    rf_wa_nx     = (state_nx == S_WB_REG) ? reg_nx : SP_IDX;
    rf_wd_nx     = (state_nx == S_WB_REG) ? rdata_nx : new_sp_nx;
    done_nx      = (state_nx == S_WB_SP) || (state_nx == S_ERR);
    err_nx       = (state_nx == S_ERR);
    pc_valid_nx  = (state_nx == S_WB_SP) && (op_nx == OP_RET);
  end

  // Registered outputs; reset drops every strobe on the next edge
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready <= 1'b1;
      rf_ra     <= SP_IDX;
      rf_we     <= 1'b0;
      rf_wa     <= 4'd0;
      rf_wd     <= 16'd0;
      mem_addr  <= 16'd0;
      mem_wdata <= 16'd0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      pc_out    <= 16'd0;
      pc_valid  <= 1'b0;
    end else begin
      cmd_ready <= cmd_ready_nx;
      rf_ra     <= rf_ra_nx;
      rf_we     <= rf_we_nx;
      rf_wa     <= rf_wa_nx;
      rf_wd     <= rf_wd_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      mem_we    <= mem_we_nx;
      mem_re    <= mem_re_nx;
      done      <= done_nx;
      err       <= err_nx;
      pc_valid  <= pc_valid_nx;
      if (pc_valid_nx) pc_out <= rdata_nx;
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl: stimulus queues expected strobes, a
// negedge monitor pops and compares each strobe the DUT presents.
module tb_stack_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_reg;
  logic [15:0] cmd_data;
  logic [3:0]  rf_ra;
  logic [15:0] rf_rd;
  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [15:0] rf_wd;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;
  logic        mem_ready = 1'b1;
  logic        done;
  logic        err;
  logic [15:0] pc_out;
  logic        pc_valid;

  always #5 clk = ~clk;

  stack_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .done(done), .err(err), .pc_out(pc_out), .pc_valid(pc_valid)
  );

  int checks = 0;
  int errors = 0;

  // Register-file model with a backdoor write port for presets
  logic [15:0] rf [16];
  logic        bd_we = 1'b0;
  logic [3:0]  bd_idx = 4'd0;
  logic [15:0] bd_val = 16'd0;
  always @(posedge clk) begin
    if (bd_we) rf[bd_idx] <= bd_val;
    else if (rf_we) rf[rf_wa] <= rf_wd;
  end
  assign rf_rd = rf[rf_ra];

  // Memory model; mem_ready held low for mem_waits_cfg cycles of each request
  logic [15:0] mem [256];
  int mem_waits_cfg = 0;
  int wait_cnt = 0;
  always @(posedge clk) if (mem_we && mem_ready) mem[mem_addr[7:0]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(negedge clk) begin
    if (!(mem_we || mem_re)) begin
      wait_cnt  <= 0;
      mem_ready <= 1'b1;
    end else if (wait_cnt < mem_waits_cfg) begin
      wait_cnt  <= wait_cnt + 1;
      mem_ready <= 1'b0;
    end else begin
      mem_ready <= 1'b1;
    end
  end

  // Cycle counter and accept stamp for latency measurement
  int cyc = 0;
  int acc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) acc <= cyc;
  end

  localparam int K_MEMW = 0;
  localparam int K_MEMR = 1;
  localparam int K_RFW  = 2;
  localparam int K_PC   = 3;
  localparam int K_DONE = 4;

  typedef struct {
    int          kind;
    logic [15:0] a;
    logic [15:0] d;
  } ev_t;
  ev_t expq[$];

  function automatic string kname(input int k);
    case (k)
      K_MEMW:  return "memw";
      K_MEMR:  return "memr";
      K_RFW:   return "rfw";
      K_PC:    return "pc";
      default: return "done";
    endcase
  endfunction

  task automatic exp_ev(input int k, input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.d    = d;
    expq.push_back(e);
  endtask

  task automatic observe(input int k, input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s got a=%h d=%h required no event", kname(k), a, d);
    end else begin
      e = expq.pop_front();
      if (e.kind != k || e.a !== a || e.d !== d) begin
        errors++;
        $display("FAIL ev_%s got %s a=%h d=%h required %s a=%h d=%h",
                 kname(e.kind), kname(k), a, d, kname(e.kind), e.a, e.d);
      end
    end
  endtask

  // Monitor: every strobe the DUT presents is matched against the queue
  always @(negedge clk) begin
    if (mem_we && mem_re) begin
      checks++;
      errors++;
      $display("FAIL mem_excl got mem_we=1 mem_re=1 required not both");
    end
    if (err && !done) begin
      checks++;
      errors++;
      $display("FAIL err_without_done got err=1 done=0 required done with err");
    end
    if (mem_we === 1'b1)   observe(K_MEMW, mem_addr, mem_wdata);
    if (mem_re === 1'b1)   observe(K_MEMR, mem_addr, 16'h0000);
    if (rf_we === 1'b1)    observe(K_RFW, {12'h000, rf_wa}, rf_wd);
    if (pc_valid === 1'b1) observe(K_PC, 16'h0000, pc_out);
    if (done === 1'b1)     observe(K_DONE, {15'h0000, err}, 16'(cyc - acc));
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, act, req);
    end
  endtask

  task automatic bd(input logic [3:0] idx, input logic [15:0] val);
    bd_idx = idx;
    bd_val = val;
    bd_we  = 1'b1;
    @(negedge clk);
    bd_we  = 1'b0;
  endtask

  // Issue one command at a negedge with cmd_ready high; return once idle again
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] r,
                         input logic [15:0] d, input int waits);
    int n;
    mem_waits_cfg = waits;
    cmd_op    = op;
    cmd_reg   = r;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!cmd_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_timeout got cmd_ready=0 required 1 within 60 cycles");
    end
  endtask

  localparam logic [1:0] PUSH = 2'b00;
  localparam logic [1:0] POP  = 2'b01;
  localparam logic [1:0] CALL = 2'b10;
  localparam logic [1:0] RET  = 2'b11;

  initial begin
    #200000;
    $display("FAIL watchdog got no finish required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_reg = 4'd0;
    cmd_data = 16'd0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cmd_ready", {15'd0, cmd_ready}, 16'd1);
    chk("rst_rf_ra", {12'd0, rf_ra}, 16'd13);
    chk("rst_strobes", {10'd0, rf_we, mem_we, mem_re, done, err, pc_valid}, 16'd0);
    chk("rst_pc_out", pc_out, 16'h0000);

    bd(4'd3, 16'h1234);
    bd(4'd13, 16'hFFFF);
    rst = 1'b0;
    @(negedge clk);

    // PUSH r3
    exp_ev(K_MEMW, 16'hFFFE, 16'h1234);
    exp_ev(K_RFW, 16'd13, 16'hFFFE);
    exp_ev(K_DONE, 16'd0, 16'd4);
    run_cmd(PUSH, 4'd3, 16'h0, 0);

    // POP r5
    exp_ev(K_MEMR, 16'hFFFE, 16'h0);
    exp_ev(K_RFW, 16'd5, 16'h1234);
    exp_ev(K_RFW, 16'd13, 16'hFFFF);
    exp_ev(K_DONE, 16'd0, 16'd4);
    run_cmd(POP, 4'd5, 16'h0, 0);

    // CALL 0x0042 then RET
    exp_ev(K_MEMW, 16'hFFFE, 16'h0042);
    exp_ev(K_RFW, 16'd13, 16'hFFFE);
    exp_ev(K_DONE, 16'd0, 16'd3);
    run_cmd(CALL, 4'd0, 16'h0042, 0);
    exp_ev(K_MEMR, 16'hFFFE, 16'h0);
    exp_ev(K_RFW, 16'd13, 16'hFFFF);
    exp_ev(K_PC, 16'h0, 16'h0042);
    exp_ev(K_DONE, 16'd0, 16'd3);
    run_cmd(RET, 4'd0, 16'h0, 0);
    chk("pc_out_hold", pc_out, 16'h0042);

    // POP on empty stack
    exp_ev(K_DONE, 16'd1, 16'd2);
    run_cmd(POP, 4'd2, 16'h0, 0);

    // PUSH at STACK_LIMIT
    bd(4'd13, 16'hFF00);
    exp_ev(K_DONE, 16'd1, 16'd2);
    run_cmd(PUSH, 4'd3, 16'h0, 0);
    chk("sp_at_limit", rf[13], 16'hFF00);
    bd(4'd13, 16'hFFFF);

    // PUSH of SP itself stores pre-decrement SP
    exp_ev(K_MEMW, 16'hFFFE, 16'hFFFF);
    exp_ev(K_RFW, 16'd13, 16'hFFFE);
    exp_ev(K_DONE, 16'd0, 16'd4);
    run_cmd(PUSH, 4'd13, 16'h0, 0);

    // POP into SP is rejected
    exp_ev(K_DONE, 16'd1, 16'd2);
    run_cmd(POP, 4'd13, 16'h0, 0);

    // POP r12
    exp_ev(K_MEMR, 16'hFFFE, 16'h0);
    exp_ev(K_RFW, 16'd12, 16'hFFFF);
    exp_ev(K_RFW, 16'd13, 16'hFFFF);
    exp_ev(K_DONE, 16'd0, 16'd4);
    run_cmd(POP, 4'd12, 16'h0, 0);

    // PUSH r14 is rejected
    exp_ev(K_DONE, 16'd1, 16'd2);
    run_cmd(PUSH, 4'd14, 16'h0, 0);
    chk("sp_after_bad_reg", rf[13], 16'hFFFF);

    // PUSH r3 with three memory wait cycles
    repeat (4) exp_ev(K_MEMW, 16'hFFFE, 16'h1234);
    exp_ev(K_RFW, 16'd13, 16'hFFFE);
    exp_ev(K_DONE, 16'd0, 16'd7);
    run_cmd(PUSH, 4'd3, 16'h0, 3);

    // POP r3 back
    exp_ev(K_MEMR, 16'hFFFE, 16'h0);
    exp_ev(K_RFW, 16'd3, 16'h1234);
    exp_ev(K_RFW, 16'd13, 16'hFFFF);
    exp_ev(K_DONE, 16'd0, 16'd4);
    run_cmd(POP, 4'd3, 16'h0, 0);

    // Reset during MEM_WR of a PUSH
    exp_ev(K_MEMW, 16'hFFFE, 16'h1234);
    mem_waits_cfg = 10;
    cmd_op = PUSH;
    cmd_reg = 4'd3;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_memwr", {15'd0, mem_we}, 16'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cmd_ready", {15'd0, cmd_ready}, 16'd1);
    chk("abort_strobes", {12'd0, rf_we, mem_we, mem_re, done}, 16'd0);
    rst = 1'b0;
    mem_waits_cfg = 0;
    repeat (4) @(negedge clk);
    chk("abort_sp", rf[13], 16'hFFFF);

    repeat (3) @(negedge clk);
    chk("queue_empty", 16'(expq.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
